// File: rtl/anim_sched_pkg.sv
// Shared constants and types for the Frogger animation scheduler.
package anim_sched_pkg;

  // Frog jump sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JUMP = 2'd1,
    LAND = 2'd2
  } frogState_t;

  // Reset period of every lane, in base ticks
  localparam int LANE_PERIOD_DEFAULT_C = 4;

  // Number of airborne frames in a jump
  localparam int JUMP_FRAMES_C = 3;

  // Width of the lane index on the configuration port
  localparam int LANE_IDX_W = 2;

  // Width of the frog sprite frame index
  localparam int FRAME_W = 2;

endpackage

// File: rtl/anim_tick_prescaler.sv
// Divides the system clock down to the shared base animation tick.
// The count freezes while paused, and no tick is issued during a pause.
module anim_tick_prescaler #(
  parameter int TICK_DIV       = 2500000,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic SC_ANIMTICK_CLOCK_50,
  input  logic SC_ANIMTICK_RESET_InHigh,
  input  logic SC_ANIMTICK_pause_InHigh,
  output logic SC_ANIMTICK_tick_Out
);

  localparam logic [PRESCALE_WIDTH-1:0] LAST_COUNT_C = PRESCALE_WIDTH'(TICK_DIV - 1);

  logic [PRESCALE_WIDTH-1:0] count_r;

  // Prescaler count: 0..TICK_DIV-1 with wrap, held while paused
  always_ff @(posedge SC_ANIMTICK_CLOCK_50 or posedge SC_ANIMTICK_RESET_InHigh) begin
    if (SC_ANIMTICK_RESET_InHigh) begin
      count_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (SC_ANIMTICK_pause_InHigh) begin
      count_r <= count_r;
    end else if (count_r == LAST_COUNT_C) begin
      count_r <= {PRESCALE_WIDTH{1'b0}};
    end else begin
      count_r <= count_r + PRESCALE_WIDTH'(1);
    end
  end

  // Tick is decoded combinationally so lanes and the frog see it in the same cycle
  assign SC_ANIMTICK_tick_Out = (count_r == LAST_COUNT_C) && !SC_ANIMTICK_pause_InHigh;

endmodule

// File: rtl/frogger_anim_scheduler.sv
// Central animation timing for Frogger: base tick, per-lane step strobes
// with programmable periods, and the frog jump frame sequencer.
module frogger_anim_scheduler
  import anim_sched_pkg::*;
#(
  parameter int TICK_DIV            = 2500000,
  parameter int PRESCALE_WIDTH      = 24,
  parameter int NUM_LANES           = 4,
  parameter int PERIOD_WIDTH        = 4,
  parameter int LANE_PERIOD_DEFAULT = LANE_PERIOD_DEFAULT_C,
  parameter int JUMP_FRAMES         = JUMP_FRAMES_C
) (
  input  logic                    SC_ANIMSCHED_CLOCK_50,
  input  logic                    SC_ANIMSCHED_RESET_InHigh,
  input  logic                    SC_ANIMSCHED_pause_InHigh,
  input  logic                    SC_ANIMSCHED_cfgWe_InHigh,
  input  logic [LANE_IDX_W-1:0]   SC_ANIMSCHED_cfgLane_InBUS,
  input  logic [PERIOD_WIDTH-1:0] SC_ANIMSCHED_cfgPeriod_InBUS,
  input  logic                    SC_ANIMSCHED_jumpReq_InHigh,
  output logic                    SC_ANIMSCHED_baseTick_Out,
  output logic [NUM_LANES-1:0]    SC_ANIMSCHED_laneStep_OutBUS,
  output logic                    SC_ANIMSCHED_jumpAck_Out,
  output logic                    SC_ANIMSCHED_frogBusy_Out,
  output logic [FRAME_W-1:0]      SC_ANIMSCHED_frogFrame_OutBUS
);

  logic baseTick_s;

  anim_tick_prescaler #(
    .TICK_DIV       (TICK_DIV),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) uPrescaler (
    .SC_ANIMTICK_CLOCK_50     (SC_ANIMSCHED_CLOCK_50),
    .SC_ANIMTICK_RESET_InHigh (SC_ANIMSCHED_RESET_InHigh),
    .SC_ANIMTICK_pause_InHigh (SC_ANIMSCHED_pause_InHigh),
    .SC_ANIMTICK_tick_Out     (baseTick_s)
  );

  assign SC_ANIMSCHED_baseTick_Out = baseTick_s;

  // ---------------------------------------------------------------------
  // Lanes: each counts base ticks down from its period and strobes once
  // when the count expires. A config write reloads only its own lane and
  // suppresses that lane's strobe if it lands on a tick.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    logic                    cfgHit_s;
    logic [PERIOD_WIDTH-1:0] period_r;
    logic [PERIOD_WIDTH-1:0] laneCnt_r;
    logic                    laneStep_r;

    // Out-of-range lane indices never match any lane
    assign cfgHit_s = SC_ANIMSCHED_cfgWe_InHigh &&
                      (SC_ANIMSCHED_cfgLane_InBUS == LANE_IDX_W'(i));

    // Lane period register, writable at any time including pause
    always_ff @(posedge SC_ANIMSCHED_CLOCK_50 or posedge SC_ANIMSCHED_RESET_InHigh) begin
      if (SC_ANIMSCHED_RESET_InHigh) begin
        period_r <= PERIOD_WIDTH'(LANE_PERIOD_DEFAULT);
      end else if (cfgHit_s) begin
        period_r <= SC_ANIMSCHED_cfgPeriod_InBUS;
      end else begin
        period_r <= period_r;
      end
    end

    // Lane countdown and registered step strobe
    always_ff @(posedge SC_ANIMSCHED_CLOCK_50 or posedge SC_ANIMSCHED_RESET_InHigh) begin
      if (SC_ANIMSCHED_RESET_InHigh) begin
        laneCnt_r  <= {PERIOD_WIDTH{1'b0}};
        laneStep_r <= 1'b0;
      end else if (cfgHit_s) begin
        laneCnt_r  <= SC_ANIMSCHED_cfgPeriod_InBUS;
        laneStep_r <= 1'b0;
      end else if (period_r == {PERIOD_WIDTH{1'b0}}) begin
        laneCnt_r  <= {PERIOD_WIDTH{1'b0}};
        laneStep_r <= 1'b0;
      end else if (baseTick_s) begin
        // A zero count after reset expires on the very first tick
        if (laneCnt_r <= PERIOD_WIDTH'(1)) begin
          laneCnt_r  <= period_r;
          laneStep_r <= 1'b1;
        end else begin
          laneCnt_r  <= laneCnt_r - PERIOD_WIDTH'(1);
          laneStep_r <= 1'b0;
        end
      end else begin
        laneCnt_r  <= laneCnt_r;
        laneStep_r <= 1'b0;
      end
    end

    assign SC_ANIMSCHED_laneStep_OutBUS[i] = laneStep_r;
  end

  // ---------------------------------------------------------------------
  // Frog jump sequencer
  // ---------------------------------------------------------------------
  frogState_t         state_r;
  frogState_t         nextState_s;
  logic [FRAME_W-1:0] frame_r;
  logic [FRAME_W-1:0] nextFrame_s;
  logic               jumpAck_r;
  logic               nextAck_s;
  logic               frogBusy_r;

  // State, frame, ack and busy registers
  always_ff @(posedge SC_ANIMSCHED_CLOCK_50 or posedge SC_ANIMSCHED_RESET_InHigh) begin
    if (SC_ANIMSCHED_RESET_InHigh) begin
      state_r    <= IDLE;
      frame_r    <= {FRAME_W{1'b0}};
      jumpAck_r  <= 1'b0;
      frogBusy_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      frame_r    <= nextFrame_s;
      jumpAck_r  <= nextAck_s;
      frogBusy_r <= (nextState_s != IDLE);
    end
  end

  // Next-state and next-frame decode; baseTick already folds in pause
  always_comb begin
    nextState_s = state_r;
    nextFrame_s = frame_r;
    nextAck_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (SC_ANIMSCHED_jumpReq_InHigh && !SC_ANIMSCHED_pause_InHigh) begin
          nextState_s = JUMP;
          nextFrame_s = FRAME_W'(1);
          nextAck_s   = 1'b1;
        end else begin
          nextState_s = IDLE;
          nextFrame_s = {FRAME_W{1'b0}};
        end
      end
      JUMP: begin
        if (baseTick_s) begin
          if (frame_r < FRAME_W'(JUMP_FRAMES)) begin
            nextFrame_s = frame_r + FRAME_W'(1);
          end else begin
            nextState_s = LAND;
            nextFrame_s = {FRAME_W{1'b0}};
          end
        end else begin
          nextState_s = JUMP;
        end
      end
      LAND: begin
        nextFrame_s = {FRAME_W{1'b0}};
        if (baseTick_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = LAND;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextFrame_s = {FRAME_W{1'b0}};
      end
    endcase
  end

  assign SC_ANIMSCHED_jumpAck_Out      = jumpAck_r;
  assign SC_ANIMSCHED_frogBusy_Out     = frogBusy_r;
  assign SC_ANIMSCHED_frogFrame_OutBUS = frame_r;

endmodule

// File: tb/tb_frogger_anim_scheduler.sv
// Scoreboard bench for frogger_anim_scheduler. The reference model tracks
// absolute base-tick numbers: each lane strobes when the tick count reaches
// its scheduled tick, and the frog frame is derived from ticks since launch.
module tb_frogger_anim_scheduler;

  localparam int TICK_DIV = 4;
  localparam int PW       = 4;
  localparam int NL       = 4;
  localparam int JF       = 3;
  localparam int DEF_P    = 4;

  typedef struct {
    logic          bt;
    logic [NL-1:0] step;
    logic          ack;
    logic          busy;
    logic [1:0]    frame;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pause = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    lane = 2'd0;
  logic [PW-1:0] per = 4'd0;
  logic          req = 1'b0;
  logic          dBt;
  logic [NL-1:0] dStep;
  logic          dAck;
  logic          dBusy;
  logic [1:0]    dFrame;

  int checks = 0;
  int errors = 0;

  exp_t expQ[$];

  // Reference model state
  int pc;
  int ticks;
  int period[NL];
  int nextTick[NL];
  logic [NL-1:0] mStep;
  logic mAck;
  logic mBusy;
  int mFrame;
  bit active;
  int jStart;

  always #5 clk = ~clk;

  frogger_anim_scheduler #(
    .TICK_DIV       (TICK_DIV),
    .PRESCALE_WIDTH (4),
    .NUM_LANES      (NL),
    .PERIOD_WIDTH   (PW),
    .LANE_PERIOD_DEFAULT (DEF_P),
    .JUMP_FRAMES    (JF)
  ) dut (
    .SC_ANIMSCHED_CLOCK_50         (clk),
    .SC_ANIMSCHED_RESET_InHigh     (rst),
    .SC_ANIMSCHED_pause_InHigh     (pause),
    .SC_ANIMSCHED_cfgWe_InHigh     (we),
    .SC_ANIMSCHED_cfgLane_InBUS    (lane),
    .SC_ANIMSCHED_cfgPeriod_InBUS  (per),
    .SC_ANIMSCHED_jumpReq_InHigh   (req),
    .SC_ANIMSCHED_baseTick_Out     (dBt),
    .SC_ANIMSCHED_laneStep_OutBUS  (dStep),
    .SC_ANIMSCHED_jumpAck_Out      (dAck),
    .SC_ANIMSCHED_frogBusy_Out     (dBusy),
    .SC_ANIMSCHED_frogFrame_OutBUS (dFrame)
  );

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endfunction

  task automatic modelReset();
    pc     = 0;
    ticks  = 0;
    for (int i = 0; i < NL; i++) begin
      period[i]   = DEF_P;
      nextTick[i] = 1;
    end
    mStep  = '0;
    mAck   = 1'b0;
    mBusy  = 1'b0;
    mFrame = 0;
    active = 1'b0;
    jStart = 0;
  endtask

  // One clock cycle: drive inputs shortly after the edge, queue what the
  // outputs must show this cycle, then advance the model over the next edge.
  task automatic cyc(input logic r, input logic p, input logic w,
                     input logic [1:0] l, input logic [PW-1:0] pr, input logic q);
    exp_t e;
    bit   bt;
    bit   idleBefore;
    int   ticksBefore;
    int   d;
    @(posedge clk);
    #1;
    rst = r; pause = p; we = w; lane = l; per = pr; req = q;
    if (r) begin
      modelReset();
      e.bt = 1'b0; e.step = '0; e.ack = 1'b0; e.busy = 1'b0; e.frame = 2'd0;
      expQ.push_back(e);
      return;
    end
    bt = !p && (pc == TICK_DIV - 1);
    e.bt = bt; e.step = mStep; e.ack = mAck; e.busy = mBusy; e.frame = 2'(mFrame);
    expQ.push_back(e);

    ticksBefore = ticks;
    if (bt) ticks++;

    for (int i = 0; i < NL; i++) begin
      mStep[i] = 1'b0;
      if (w && (int'(l) == i)) begin
        period[i]   = int'(pr);
        nextTick[i] = ticks + int'(pr);
      end else if (bt && period[i] != 0 && ticks == nextTick[i]) begin
        mStep[i]    = 1'b1;
        nextTick[i] = nextTick[i] + period[i];
      end
    end

    mAck = 1'b0;
    idleBefore = !active || (ticksBefore >= jStart + JF + 1);
    if (idleBefore) active = 1'b0;
    if (idleBefore && q && !p) begin
      active = 1'b1;
      jStart = ticks;
      mAck   = 1'b1;
    end
    if (active) begin
      d = ticks - jStart;
      if (d < JF) begin
        mFrame = 1 + d; mBusy = 1'b1;
      end else if (d == JF) begin
        mFrame = 0; mBusy = 1'b1;
      end else begin
        mFrame = 0; mBusy = 1'b0; active = 1'b0;
      end
    end else begin
      mFrame = 0; mBusy = 1'b0;
    end

    if (!p) pc = (pc + 1) % TICK_DIV;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  // Monitor: compare every presented output against the queued expectation
  exp_t monE;
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("baseTick", int'(dBt),    int'(monE.bt));
      chk("laneStep", int'(dStep),  int'(monE.step));
      chk("jumpAck",  int'(dAck),   int'(monE.ack));
      chk("frogBusy", int'(dBusy),  int'(monE.busy));
      chk("frogFrame", int'(dFrame), int'(monE.frame));
    end
  end

  initial begin
    bit found;
    modelReset();

    // Reset held, then released with default periods
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    idle(40);

    // Lane 2 every tick, lane 0 disabled
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 4'd1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0);
    idle(30);

    // Write lane 1 on the very tick that would strobe it
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (pc == TICK_DIV - 1 && period[1] != 0 && ticks + 1 == nextTick[1]) begin
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 4'd3, 1'b0);
        found = 1'b1;
      end else begin
        idle(1);
      end
    end
    chk("lane1 collision reached", int'(found), 1);
    idle(30);

    // Jump pulse, then a second request mid-jump
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    idle(25);

    // Pause for 10 cycles mid-jump, then resume
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    idle(6);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    idle(30);

    // Request while paused in IDLE is ignored; held request fires on resume
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    idle(25);

    // Reset mid-jump at frame 2, between clock edges
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (mFrame == 2) found = 1'b1;
      else idle(1);
    end
    chk("frame 2 reached", int'(found), 1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    idle(40);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 15) == 0),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frogger_anim_scheduler.md
Name: frogger_anim_scheduler

Overview:
Central timing controller for all moving objects in the Frogger game.
- Divides CLOCK_50 into a shared base animation tick.
- Schedules per-lane step strobes for cars and logs, each lane with a programmable period.
- Sequences the frog jump animation frames.
- Sits between the top-level game FSM / input logic and the lane position registers and sprite renderer.

Parameters:
TICK_DIV, 2500000, CLOCK_50 cycles per base tick (20 Hz); minimum 2.
PRESCALE_WIDTH, 24, prescaler counter width; must satisfy 2^PRESCALE_WIDTH >= TICK_DIV.
NUM_LANES, 4, number of independently scheduled lanes.
PERIOD_WIDTH, 4, width of each lane period, in base ticks.
LANE_PERIOD_DEFAULT, 4, reset period for every lane.
JUMP_FRAMES, 3, number of jump frames shown (1..3).

Ports:
SC_ANIMSCHED_CLOCK_50  in  1  system clock, 50 MHz
SC_ANIMSCHED_RESET_InHigh  in  1  asynchronous, active-high reset
SC_ANIMSCHED_pause_InHigh  in  1  1 = freeze prescaler, lanes and frog FSM
SC_ANIMSCHED_cfgWe_InHigh  in  1  lane period write strobe
SC_ANIMSCHED_cfgLane_InBUS  in  2  lane index for the write
SC_ANIMSCHED_cfgPeriod_InBUS  in  PERIOD_WIDTH  new period; 0 = lane disabled
SC_ANIMSCHED_jumpReq_InHigh  in  1  frog jump request (level or pulse)
SC_ANIMSCHED_baseTick_Out  out  1  one-cycle base tick, combinational
SC_ANIMSCHED_laneStep_OutBUS  out  NUM_LANES  one-cycle step strobes, registered
SC_ANIMSCHED_jumpAck_Out  out  1  one-cycle accept pulse, registered
SC_ANIMSCHED_frogBusy_Out  out  1  1 while the state is JUMP or LAND
SC_ANIMSCHED_frogFrame_OutBUS  out  2  current frog sprite frame

Behaviour:
Reset:
- Async assert clears the prescaler to 0, every lane counter and laneStep to 0, jumpAck to 0, frogFrame to 0 and the FSM to IDLE.
- Lane periods reset to LANE_PERIOD_DEFAULT.
- Lane counters reload from their period on the first base tick after reset.
- Reset asserted mid-jump aborts the jump immediately; no ack or frame is left pending.

Prescaler:
- Counts 0..TICK_DIV-1, then wraps to 0.
- baseTick = (count == TICK_DIV-1) && !pause.
- When pause=1 the count holds.

Lanes (each i):
- On baseTick, with period_i != 0:
  - counter_i <= 1 (including 0 after reset): laneStep[i]=1 on the next cycle; counter_i reloads to period_i.
  - otherwise: counter_i decrements.
- period_i == 0: counter_i held at 0; laneStep[i] never asserts.
- Step latency: exactly 1 cycle after baseTick. Period P gives one strobe every P base ticks.
- cfgWe writes period[cfgLane] and reloads counter[cfgLane] with cfgPeriod in the same cycle.
  - If it coincides with baseTick, the write wins for that lane only; no strobe from that lane that tick.
  - Other lanes are unaffected.
- Writes are accepted while paused.
- cfgLane >= NUM_LANES is ignored.

Frog FSM (IDLE, JUMP, LAND):
- IDLE: frame=0, busy=0. jumpReq && !pause moves to JUMP, frame<=1, jumpAck=1 for one cycle (next cycle).
- JUMP: on baseTick, if frame < JUMP_FRAMES then frame++; else move to LAND, frame<=0.
- LAND: busy=1; the next baseTick moves to IDLE.
- jumpReq outside IDLE, or while paused, is ignored with no ack; no queuing.
- A held jumpReq re-triggers only after the FSM returns to IDLE.
- Pause freezes the state and frame.

Decomposition:
Package anim_sched_pkg holds:
- FSM state encoding (IDLE=2'd0, JUMP=2'd1, LAND=2'd2).
- Default period and JUMP_FRAMES constants.
- Lane index width.

Sub-module anim_tick_prescaler:
- Parameterised counter with clock, async reset and pause inputs.
- Outputs the tick.
- Instantiated once.

Lanes and the FSM live in the top module, with the lanes in a generate loop.

Test Plan:
(Simulation uses TICK_DIV=4.)
1. Release reset, default periods -> baseTick every 4 cycles; each laneStep strobes 1 cycle after every 4th baseTick; all outputs 0 during reset.
2. Write lane2 period=1, lane0 period=0 -> lane2 strobes after every baseTick; lane0 never strobes; lanes 1 and 3 unchanged.
3. cfgWe to lane1 in the same cycle as the baseTick that would strobe lane1 -> no lane1 strobe that tick; next strobe follows the new period.
4. jumpReq pulse in IDLE -> jumpAck next cycle; frames 1,2,3 on successive baseTicks, then LAND (frame 0, busy=1), then IDLE after one more baseTick; a second jumpReq during JUMP gets no ack.
5. pause=1 for 10 cycles mid-jump -> prescaler, frame and lane counters hold; no baseTick or strobes; resume continues from the held state.
6. Assert reset during JUMP, frame=2, asynchronously between clock edges -> outputs clear immediately; periods return to 4.
